small_poly_encoder: RTL and testbench
=====================================

Name: small_poly_encoder

Overview:
- Reader/consumer of the small (ternary) polynomial that the small-polynomial generator writes into coefficient memory.
- Reads the P coefficients in {-1,0,1} (13-bit two's complement), performs NTRU Prime Small_encode (4 coefficients per byte, 2 bits each, value c+1), and streams ceil(P/4) bytes out on a valid/ready interface.
- Also reports the Hamming weight and flags illegal coefficients. Used in key/ciphertext serialisation for SNTRUP757.

Parameters:
P, 757, polynomial length (coefficient count)
W, 286, required Hamming weight (used only with SMALL_WEIGHT_CHECK_EN)
AW, 11, memory address width
CW, 13, coefficient word width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begin encoding when idle
mem_address_o  out  AW  coefficient read address (registered)
mem_output  in  CW  read data; valid one cycle after mem_address_o is presented
byte_out  out  8  encoded byte
byte_valid  out  1  byte_out holds a valid byte
byte_ready  in  1  downstream accepts byte when byte_valid and byte_ready are both high
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the last byte is accepted
bad_coeff  out  1  sticky; an illegal coefficient was seen this run
weight  out  AW  count of nonzero legal coefficients this run

Behaviour:
- Reset: state IDLE; mem_address_o=0, byte_out=0, byte_valid=0, busy=0, done=0, bad_coeff=0, weight=0. Reset mid-run aborts immediately: no done, partial byte discarded.
- States:
  - IDLE: on start, clear bad_coeff, weight, coefficient index k, lane j and the byte accumulator; go to FETCH. start while busy is ignored.
  - FETCH: drive mem_address_o=k; go to CAPT.
  - CAPT: sample mem_output and decode it:
    - 0x0000 -> field 2'b01
    - 0x0001 -> field 2'b10, weight+1
    - 0x1FFF -> field 2'b00, weight+1
    - any other value -> field 2'b01 and bad_coeff=1
  - CAPT (continued): write the field to accumulator bits [2j+1:2j] and increment k.
    - If j==3 or k==P-1: go to EMIT.
    - Otherwise j+1 and back to FETCH.
  - EMIT: byte_out=accumulator, byte_valid=1. Unfilled lanes of a partial final byte are 0; for P=757 the last byte is f[756]+1.
    - Hold byte_out and byte_valid stable until byte_ready. byte_valid must not depend combinationally on byte_ready.
    - On handshake: if that was the last byte, go to DONE; else clear the accumulator, set j=0, go to FETCH.
  - DONE: done=1 for exactly one cycle, busy=0, byte_valid=0; go to IDLE. weight and bad_coeff hold until the next start.
- Byte order: byte n holds coefficients 4n..4n+3, with coefficient 4n in bits [1:0].
- Timing: 2 cycles per coefficient plus at least 1 EMIT cycle per byte. With byte_ready held high, a P=757 run is 190 bytes, 757*2+190 = 1704 cycles from start to done.
- Counters: k is AW bits; P must be at most 2^AW. weight saturates at 2^AW-1.

Optional Feature:
- Macro: SMALL_WEIGHT_CHECK_EN.
- Defined:
  - Adds output port weight_err (1 bit). It is set in the DONE cycle when weight != W, and cleared on start and on rst.
  - The final byte is still emitted normally.
- Undefined:
  - Port weight_err is absent.
  - No comparison against W; weight is still reported.

Test Plan:
- All-zero memory, byte_ready=1 -> 189 bytes 0x55 then 0x01; weight=0; bad_coeff=0; done exactly 1704 cycles after start.
- Repeating pattern {1,-1,0,1} (0x0001,0x1FFF,0x0000,0x0001), f[756]=-1 -> 189 bytes 0x92 then 0x00; weight=568 (189*3+1).
- Random backpressure (byte_ready ~50%) -> byte_out/byte_valid stable while stalled; byte stream identical to the ready=1 run; exactly 190 handshakes.
- Coefficient 5 at index 10, rest zero -> byte 2 = 0x55, bad_coeff=1 sticky until next start, weight=0.
- rst asserted at byte 50, then a new start -> no done from the aborted run; the second run produces the full correct 190-byte stream.
- SMALL_WEIGHT_CHECK_EN, polynomial with exactly 286 nonzeros -> weight_err=0; with 285 nonzeros -> weight_err=1 at done.

Source files
------------

// File: rtl/small_poly_encoder.sv
// small_poly_encoder
//   Reads P ternary coefficients (13-bit two's complement, values -1/0/+1)
//   from coefficient memory and streams the NTRU Prime Small_encode bytes:
//   four coefficients per byte, two bits each, field value c+1, with the
//   lowest-index coefficient in bits [1:0]. It also reports the Hamming
//   weight and flags any coefficient outside {-1,0,1}.
//
//   Optional feature macro: SMALL_WEIGHT_CHECK_EN
//     When defined, adds parameter W and output weight_err. weight_err is
//     set in the DONE cycle when weight != W.
//
//   Byte handshake: byte_valid is driven purely from state (never from
//   byte_ready). Once raised, byte_out and byte_valid stay stable until a
//   cycle where byte_valid && byte_ready are both high; that cycle is the
//   transfer.
//
//   Memory timing: mem_address_o is a register that always mirrors k, so it
//   already holds k during FETCH and the memory returns the word in CAPT.
module small_poly_encoder #(
  parameter int P  = 757,
`ifdef SMALL_WEIGHT_CHECK_EN
  parameter int W  = 286,
`endif
  parameter int AW = 11,
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] mem_address_o,
  input  logic [CW-1:0] mem_output,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          busy,
  output logic          done,
  output logic          bad_coeff,
  output logic [AW-1:0] weight
`ifdef SMALL_WEIGHT_CHECK_EN
  ,
  output logic          weight_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAPT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] K_LAST   = AW'(P - 1);
  localparam logic [CW-1:0] C_ZERO   = '0;
  localparam logic [CW-1:0] C_PLUS1  = CW'(1);
  localparam logic [CW-1:0] C_MINUS1 = '1;

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    j_q, j_d;
  logic [7:0]    acc_q, acc_d;
  logic          last_q, last_d;
  logic [AW-1:0] weight_q, weight_d;
  logic          bad_q, bad_d;

  logic [1:0]    field;
  logic          coeff_nz;
  logic          coeff_bad;

  // Decode one memory word into its 2-bit Small_encode field.
  always_comb begin
    field     = 2'b01;
    coeff_nz  = 1'b0;
    coeff_bad = 1'b0;
    case (mem_output)
      C_ZERO:   field = 2'b01;
      C_PLUS1:  begin field = 2'b10; coeff_nz = 1'b1; end
      C_MINUS1: begin field = 2'b00; coeff_nz = 1'b1; end
      default:  begin field = 2'b01; coeff_bad = 1'b1; end
    endcase
  end

  // Next-state and datapath updates for the fetch/capture/emit sequence.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    j_d      = j_q;
    acc_d    = acc_q;
    last_d   = last_q;
    weight_d = weight_q;
    bad_d    = bad_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d      = '0;
          j_d      = 2'd0;
          acc_d    = 8'h00;
          last_d   = 1'b0;
          weight_d = '0;
          bad_d    = 1'b0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        acc_d[2*j_q +: 2] = field;
        if (coeff_nz && (weight_q != '1)) weight_d = weight_q + 1'b1;
        if (coeff_bad) bad_d = 1'b1;
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) last_d = 1'b1;
        if ((j_q == 2'd3) || (k_q == K_LAST)) begin
          state_d = S_EMIT;
        end else begin
          j_d     = j_q + 2'd1;
          state_d = S_FETCH;
        end
      end
      S_EMIT: begin
        if (byte_ready) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            acc_d   = 8'h00;
            j_d     = 2'd0;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    addr_d = k_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      addr_q   <= '0;
      j_q      <= 2'd0;
      acc_q    <= 8'h00;
      last_q   <= 1'b0;
      weight_q <= '0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      last_q   <= last_d;
      weight_q <= weight_d;
      bad_q    <= bad_d;
    end
  end

`ifdef SMALL_WEIGHT_CHECK_EN
  logic weight_err_q;

  // Weight-mismatch flag: cleared on start, evaluated in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_err_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      weight_err_q <= 1'b0;
    end else if (state_q == S_DONE) begin
      weight_err_q <= (weight_q != AW'(W));
    end
  end

  assign weight_err = weight_err_q;
`endif

  assign mem_address_o = addr_q;
  assign byte_valid    = (state_q == S_EMIT);
  assign byte_out      = (state_q == S_EMIT) ? acc_q : 8'h00;
  assign busy          = (state_q == S_FETCH) || (state_q == S_CAPT) || (state_q == S_EMIT);
  assign done          = (state_q == S_DONE);
  assign bad_coeff     = bad_q;
  assign weight        = weight_q;

endmodule

// File: tb/tb_small_poly_encoder.sv
// Directed testbench for small_poly_encoder (P=757).
module tb_small_poly_encoder;

  localparam int P  = 757;
  localparam int AW = 11;
  localparam int CW = 13;
  localparam int NBYTES = 190;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] mem_address_o;
  logic [CW-1:0] mem_output;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready;
  logic          busy;
  logic          done;
  logic          bad_coeff;
  logic [AW-1:0] weight;
`ifdef SMALL_WEIGHT_CHECK_EN
  logic          weight_err;
`endif

  small_poly_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_address_o (mem_address_o),
    .mem_output    (mem_output),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .busy          (busy),
    .done          (done),
    .bad_coeff     (bad_coeff),
    .weight        (weight)
`ifdef SMALL_WEIGHT_CHECK_EN
    ,
    .weight_err    (weight_err)
`endif
  );

  // coefficient memory: synchronous read, data one cycle after the address
  logic [CW-1:0] mem [0:P-1];
  always @(posedge clk) begin
    if (int'(mem_address_o) < P) mem_output <= mem[int'(mem_address_o)];
    else                         mem_output <= '0;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic fill_zero();
    for (int i = 0; i < P; i++) mem[i] = 13'h0000;
  endtask

  // {1,-1,0,1} repeating, last coefficient -1
  task automatic fill_pattern();
    for (int i = 0; i < P; i++) begin
      case (i % 4)
        0: mem[i] = 13'h0001;
        1: mem[i] = 13'h1FFF;
        2: mem[i] = 13'h0000;
        default: mem[i] = 13'h0001;
      endcase
    end
    mem[P-1] = 13'h1FFF;
  endtask

  task automatic load_exp(input logic [7:0] body_b, input logic [7:0] last_b);
    exp_q.delete();
    for (int i = 0; i < NBYTES - 1; i++) exp_q.push_back(body_b);
    exp_q.push_back(last_b);
  endtask

  // One full run: start, collect bytes against exp_q, check stalls and totals.
  task automatic run_encode(input string tag, input int bp, input int exp_cycles,
                            input logic [AW-1:0] exp_w, input logic exp_bad);
    int n;
    int hs;
    logic pv;
    logic pr;
    logic [7:0] pb;
    logic [7:0] e;
    n = 0; hs = 0; pv = 1'b0; pr = 1'b0; pb = 8'h00;
    @(negedge clk);
    start = 1'b1;
    byte_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_bad_cleared"}, bad_coeff, 0);
    check({tag, "_weight_cleared"}, weight, 0);
    while (1) begin
      if (done) break;
      if (n > 5000) begin
        checks++;
        failures++;
        $error("FAIL %s_timeout observed=%0d expected<=5000", tag, n);
        break;
      end
      byte_ready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = ((bp != 0) && (n == 300)) ? 1'b1 : 1'b0;
      if (pv && !pr) begin
        check({tag, "_stall_valid"}, byte_valid, 1);
        check({tag, "_stall_hold"}, byte_out, pb);
      end
      if (byte_valid && byte_ready) begin
        hs++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_byte"}, byte_out, e);
        end else begin
          check({tag, "_extra_byte"}, hs, NBYTES);
        end
      end
      pv = byte_valid;
      pr = byte_ready;
      pb = byte_out;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (exp_cycles >= 0) check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_handshakes"}, hs, NBYTES);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_weight"}, weight, exp_w);
    check({tag, "_bad"}, bad_coeff, exp_bad);
    check({tag, "_done_valid_low"}, byte_valid, 0);
    check({tag, "_done_busy_low"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_weight_hold"}, weight, exp_w);
    check({tag, "_bad_hold"}, bad_coeff, exp_bad);
  endtask

  initial begin : main
    int hs;
    int bound;
    int done_seen;

    // reset
    rst = 1'b1; start = 1'b0; byte_ready = 1'b0;
    fill_zero();
    repeat (3) @(negedge clk);
    check("rst_addr", mem_address_o, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bad", bad_coeff, 0);
    check("rst_weight", weight, 0);
    rst = 1'b0;
    @(negedge clk);

    // all-zero polynomial: 189 x 0x55 then 0x01, 1704 cycles
    load_exp(8'h55, 8'h01);
    run_encode("zero", 0, 1704, 11'd0, 1'b0);

    // {1,-1,0,1} pattern: 189 x 0x92 then 0x00, weight 568
    fill_pattern();
    load_exp(8'h92, 8'h00);
    run_encode("pattern", 0, 1704, 11'd568, 1'b0);

    // same stream under random backpressure, with a start pulse mid-run
    load_exp(8'h92, 8'h00);
    run_encode("backpressure", 1, -1, 11'd568, 1'b0);

    // illegal coefficient 5 at index 10 -> lane encodes as zero, bad sticky
    fill_zero();
    mem[10] = 13'h0005;
    load_exp(8'h55, 8'h01);
    run_encode("bad_coeff", 0, 1704, 11'd0, 1'b1);
    repeat (5) @(negedge clk);
    check("bad_sticky", bad_coeff, 1);
    mem[10] = 13'h0000;
    load_exp(8'h55, 8'h01);
    run_encode("bad_rerun", 0, 1704, 11'd0, 1'b0);

    // reset at byte 50 aborts the run
    fill_pattern();
    @(negedge clk);
    start = 1'b1; byte_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0; bound = 0;
    while ((hs < 50) && (bound < 2000)) begin
      if (byte_valid && byte_ready) hs++;
      @(negedge clk);
      bound++;
    end
    check("abort_reached_byte50", hs, 50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", byte_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_addr", mem_address_o, 0);
    check("abort_weight", weight, 0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", done_seen, 0);
    load_exp(8'h92, 8'h00);
    run_encode("after_abort", 0, 1704, 11'd568, 1'b0);

`ifdef SMALL_WEIGHT_CHECK_EN
    // exactly 286 nonzeros: 71 x 0xAA, 0x5A, 117 x 0x55, 0x01
    fill_zero();
    for (int i = 0; i < 286; i++) mem[i] = 13'h0001;
    exp_q.delete();
    for (int i = 0; i < 71; i++) exp_q.push_back(8'hAA);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 117; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'h01);
    run_encode("w286", 0, 1704, 11'd286, 1'b0);
    check("w286_weight_err", weight_err, 0);

    // 285 nonzeros: byte 71 becomes 0x56
    mem[285] = 13'h0000;
    exp_q.delete();
    for (int i = 0; i < 71; i++) exp_q.push_back(8'hAA);
    exp_q.push_back(8'h56);
    for (int i = 0; i < 117; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'h01);
    run_encode("w285", 0, 1704, 11'd285, 1'b0);
    check("w285_weight_err", weight_err, 1);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
